mem_bridge: RTL and testbench

Memory-side responder for the CPU control state machine. It accepts one access request at a time from the control unit, routes it to instruction RAM or data RAM, waits out the block-RAM read latency and returns read data with a one-cycle acknowledge. It sits between the control unit and the memory-address register and bus paths on one side, and the IRAM and DRAM block RAMs on the other.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/mem_wait_cnt.sv | 31 +++
 rtl/mem_bridge.sv | 136 +++++++++++++
 tb/tb_mem_bridge.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory target select codes, mem_bridge state
// encoding, default bus widths and the access legality rule.
package cpu_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    // Target select codes, also driven by the control unit.
    localparam logic [1:0] SEL_IRAM = 2'b01;
    localparam logic [1:0] SEL_DRAM = 2'b10;

    typedef enum logic [1:0] {
        MB_IDLE  = 2'd0,
        MB_ISSUE = 2'd1,
        MB_WAIT  = 2'd2,
        MB_DONE  = 2'd3
    } mb_state_t;

    // An access is legal when it targets DRAM, or is a read of IRAM
    // (IRAM is read-only; 2'b00 and 2'b11 select nothing).
    function automatic logic access_legal(input logic [1:0] sel_f, input logic we_f);
        access_legal = (sel_f == SEL_DRAM) || ((sel_f == SEL_IRAM) && !we_f);
    endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// Loadable down-counter used to wait out the block-RAM read latency.
// last is high while the count equals one.
module mem_wait_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] cnt_r;

    // Load takes priority; otherwise count down while enabled, saturating at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != '0)) begin
            cnt_r <= cnt_r - W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign last = (cnt_r == W'(1));

endmodule

// File: rtl/mem_bridge.sv
// Memory-side responder: takes one request at a time from the control unit,
// steers it to IRAM or DRAM, waits the read latency, and returns data with
// a one-cycle ack (plus err for illegal accesses).
module mem_bridge
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output logic              iram_en,
    output logic [ADDR_W-1:0] iram_addr,
    input  logic [DATA_W-1:0] iram_rdata,
    output logic              dram_en,
    output logic              dram_we,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [DATA_W-1:0] dram_wdata,
    input  logic [DATA_W-1:0] dram_rdata
);

    localparam int CNT_W = $clog2(RD_LAT + 1);

    mb_state_t  state_r;
    logic       we_r;
    logic [1:0] sel_r;
    logic       cnt_load_s;
    logic       cnt_en_s;
    logic       cnt_last_s;

    // The counter is loaded while a read sits in ISSUE and runs during WAIT.
    assign cnt_load_s = (state_r == MB_ISSUE) && !we_r;
    assign cnt_en_s   = (state_r == MB_WAIT);

    mem_wait_cnt #(
        .W (CNT_W)
    ) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load_s),
        .en       (cnt_en_s),
        .load_val (CNT_W'(RD_LAT)),
        .last     (cnt_last_s)
    );

    // Access sequencer; all outputs are registered so enables and ack are glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= MB_IDLE;
            we_r       <= 1'b0;
            sel_r      <= 2'b00;
            rdata      <= '0;
            ack        <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            iram_en    <= 1'b0;
            iram_addr  <= '0;
            dram_en    <= 1'b0;
            dram_we    <= 1'b0;
            dram_addr  <= '0;
            dram_wdata <= '0;
        end else begin
            // Pulses and enables are single-cycle unless re-asserted below.
            ack     <= 1'b0;
            err     <= 1'b0;
            iram_en <= 1'b0;
            dram_en <= 1'b0;
            dram_we <= 1'b0;
            case (state_r)
                MB_IDLE: begin
                    if (req) begin
                        we_r  <= we;
                        sel_r <= sel;
                        busy  <= 1'b1;
                        if (!access_legal(sel, we)) begin
                            // Illegal access: straight to DONE, no memory touched.
                            state_r <= MB_DONE;
                            ack     <= 1'b1;
                            err     <= 1'b1;
                        end else begin
                            // Enables are set here so they are high during ISSUE.
                            state_r <= MB_ISSUE;
                            if (sel == SEL_IRAM) begin
                                iram_en   <= 1'b1;
                                iram_addr <= addr;
                            end else begin
                                dram_en    <= 1'b1;
                                dram_we    <= we;
                                dram_addr  <= addr;
                                dram_wdata <= wdata;
                            end
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                MB_ISSUE: begin
                    if (we_r) begin
                        state_r <= MB_DONE;
                        ack     <= 1'b1;
                    end else begin
                        state_r <= MB_WAIT;
                    end
                end
                MB_WAIT: begin
                    if (cnt_last_s) begin
                        rdata   <= (sel_r == SEL_IRAM) ? iram_rdata : dram_rdata;
                        state_r <= MB_DONE;
                        ack     <= 1'b1;
                    end else begin
                        state_r <= MB_WAIT;
                    end
                end
                MB_DONE: begin
                    state_r <= MB_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= MB_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Self-checking bench for mem_bridge: two instances (read latency 1 and 3),
// block-RAM models with exact-cycle read data, and a reference model of
// access latency, enables, error and returned data.
module tb_mem_bridge;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       fill;
    logic       req_v [2];
    logic       we_v [2];
    logic [1:0] sel_v [2];
    logic [7:0] addr_v [2];
    logic [7:0] wdata_v [2];
    logic [7:0] rdata_v [2];
    logic       ack_v [2];
    logic       err_v [2];
    logic       busy_v [2];
    logic       iram_en_v [2];
    logic [7:0] iram_addr_v [2];
    logic [7:0] iram_rdata_v [2];
    logic       dram_en_v [2];
    logic       dram_we_v [2];
    logic [7:0] dram_addr_v [2];
    logic [7:0] dram_wdata_v [2];
    logic [7:0] dram_rdata_v [2];

    mem_bridge #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut0 (
        .clk(clk), .rst(rst), .req(req_v[0]), .we(we_v[0]), .sel(sel_v[0]),
        .addr(addr_v[0]), .wdata(wdata_v[0]), .rdata(rdata_v[0]), .ack(ack_v[0]),
        .err(err_v[0]), .busy(busy_v[0]), .iram_en(iram_en_v[0]),
        .iram_addr(iram_addr_v[0]), .iram_rdata(iram_rdata_v[0]),
        .dram_en(dram_en_v[0]), .dram_we(dram_we_v[0]), .dram_addr(dram_addr_v[0]),
        .dram_wdata(dram_wdata_v[0]), .dram_rdata(dram_rdata_v[0])
    );

    mem_bridge #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3)) dut1 (
        .clk(clk), .rst(rst), .req(req_v[1]), .we(we_v[1]), .sel(sel_v[1]),
        .addr(addr_v[1]), .wdata(wdata_v[1]), .rdata(rdata_v[1]), .ack(ack_v[1]),
        .err(err_v[1]), .busy(busy_v[1]), .iram_en(iram_en_v[1]),
        .iram_addr(iram_addr_v[1]), .iram_rdata(iram_rdata_v[1]),
        .dram_en(dram_en_v[1]), .dram_we(dram_we_v[1]), .dram_addr(dram_addr_v[1]),
        .dram_wdata(dram_wdata_v[1]), .dram_rdata(dram_rdata_v[1])
    );

    // Block-RAM models: read data is valid only in the one cycle RD_LAT after
    // the enable; every other cycle shows filler 8'hEE.
    logic [7:0] iram_mem [2][256];
    logic [7:0] dram_mem [2][256];
    logic [7:0] ipipe [2][3];
    logic [7:0] dpipe [2][3];

    function automatic logic [7:0] dram_init(input int d, input int a);
        return 8'((a * 7) + (d * 13) + 3);
    endfunction

    // RAM behaviour for both instances.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            ipipe[d][0] <= iram_en_v[d] ? iram_mem[d][iram_addr_v[d]] : 8'hEE;
            dpipe[d][0] <= (dram_en_v[d] && !dram_we_v[d]) ? dram_mem[d][dram_addr_v[d]] : 8'hEE;
            for (int k = 1; k < 3; k++) begin
                ipipe[d][k] <= ipipe[d][k-1];
                dpipe[d][k] <= dpipe[d][k-1];
            end
            if (fill) begin
                for (int a = 0; a < 256; a++) dram_mem[d][a] <= dram_init(d, a);
            end else if (dram_en_v[d] && dram_we_v[d]) begin
                dram_mem[d][dram_addr_v[d]] <= dram_wdata_v[d];
            end
        end
    end

    assign iram_rdata_v[0] = ipipe[0][0];
    assign dram_rdata_v[0] = dpipe[0][0];
    assign iram_rdata_v[1] = ipipe[1][2];
    assign dram_rdata_v[1] = dpipe[1][2];

    // Reference model state.
    logic [7:0] ref_dram [2][256];
    logic [7:0] last_rd [2];
    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // One access with the bench's expectations computed from the rules:
    // illegal -> ack in cycle 1; write -> cycle 2; read -> cycle 2+latency.
    task automatic access(input int d, input logic [1:0] s, input logic w,
                          input logic [7:0] a, input logic [7:0] wd, input string tag);
        logic        legal;
        int          lat_exp;
        int          ack_cyc;
        logic        err_obs;
        logic [7:0]  rd_obs;
        logic [15:0] im, dm, wm, im_e, dm_e, wm_e;
        legal   = (s == SEL_DRAM) || ((s == SEL_IRAM) && !w);
        lat_exp = !legal ? 1 : (w ? 2 : 2 + lat_of(d));
        im_e = (legal && s == SEL_IRAM) ? 16'h0002 : 16'h0000;
        dm_e = (legal && s == SEL_DRAM) ? 16'h0002 : 16'h0000;
        wm_e = (legal && s == SEL_DRAM && w) ? 16'h0002 : 16'h0000;
        if (legal && !w) last_rd[d] = (s == SEL_IRAM) ? iram_mem[d][a] : ref_dram[d][a];
        if (legal && w) ref_dram[d][a] = wd;

        @(negedge clk);
        req_v[d] = 1'b1; we_v[d] = w; sel_v[d] = s; addr_v[d] = a; wdata_v[d] = wd;
        @(posedge clk);
        ack_cyc = 0; err_obs = 1'b0; rd_obs = 8'h00;
        im = 16'h0; dm = 16'h0; wm = 16'h0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (iram_en_v[d]) im[c] = 1'b1;
            if (dram_en_v[d]) dm[c] = 1'b1;
            if (dram_we_v[d]) wm[c] = 1'b1;
            if (c == 1) begin
                // Inputs may wander once the access is accepted.
                req_v[d] = 1'b0; we_v[d] = 1'($urandom); sel_v[d] = 2'($urandom);
                addr_v[d] = 8'($urandom); wdata_v[d] = 8'($urandom);
            end
            if (ack_v[d]) begin
                ack_cyc = c; err_obs = err_v[d]; rd_obs = rdata_v[d];
                break;
            end
        end
        chk({tag, "_ack_cycle"}, ack_cyc, lat_exp);
        chk({tag, "_err"}, err_obs, !legal);
        chk({tag, "_iram_en"}, im, im_e);
        chk({tag, "_dram_en"}, dm, dm_e);
        chk({tag, "_dram_we"}, wm, wm_e);
        chk({tag, "_rdata"}, rd_obs, last_rd[d]);
        @(negedge clk);
        chk({tag, "_idle_after"}, {busy_v[d], ack_v[d]}, 2'b00);
    endtask

    task automatic rand_run(input int d, input int n);
        int         r;
        logic [1:0] s;
        logic       w;
        logic [7:0] a;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 7);
            s = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r <= 4) ? SEL_IRAM : SEL_DRAM;
            w = 1'($urandom_range(0, 1));
            a = (s == SEL_DRAM) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            access(d, s, w, a, 8'($urandom), "rand");
        end
    endtask

    initial begin
        logic [15:0] am, dm;
        int          acks;
        rst = 1'b1; fill = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_v[d] = 1'b0; we_v[d] = 1'b0; sel_v[d] = 2'b00;
            addr_v[d] = 8'h00; wdata_v[d] = 8'h00; last_rd[d] = 8'h00;
            for (int a = 0; a < 256; a++) begin
                iram_mem[d][a] = 8'($urandom);
                ref_dram[d][a] = dram_init(d, a);
            end
            iram_mem[d][8'h10] = 8'hA5;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_outputs", {rdata_v[d], ack_v[d], err_v[d], busy_v[d], iram_en_v[d],
                dram_en_v[d], dram_we_v[d]}, 32'h0);
            chk("reset_addr_data", {iram_addr_v[d], dram_addr_v[d], dram_wdata_v[d]}, 32'h0);
        end
        rst = 1'b0; fill = 1'b0;
        repeat (2) @(negedge clk);

        // Directed accesses, latency 1.
        access(0, SEL_IRAM, 1'b0, 8'h10, 8'h00, "iram_rd");
        chk("iram_rd_a5", rdata_v[0], 8'hA5);
        access(0, SEL_DRAM, 1'b1, 8'h20, 8'h3C, "dram_wr");
        access(0, SEL_DRAM, 1'b0, 8'h20, 8'h00, "dram_rd");
        chk("dram_rd_3c", rdata_v[0], 8'h3C);
        access(0, SEL_IRAM, 1'b1, 8'h11, 8'h77, "iram_wr_err");
        access(0, 2'b00, 1'b0, 8'h12, 8'h00, "sel00_err");
        access(0, 2'b11, 1'b1, 8'h13, 8'h55, "sel11_err");

        // Reset in the middle of a DRAM read.
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b0; sel_v[0] = SEL_DRAM; addr_v[0] = 8'h20;
        @(posedge clk);
        @(negedge clk);
        req_v[0] = 1'b0;
        chk("midrst_en_before", dram_en_v[0], 1'b1);
        #1 rst = 1'b1;
        #1 chk("midrst_en_drop", {dram_en_v[0], busy_v[0]}, 2'b00);
        acks = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ack_v[0]) acks++;
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ack_v[0]) acks++;
        end
        chk("midrst_no_ack", acks, 0);
        chk("midrst_rdata", rdata_v[0], 8'h00);
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;

        // req held high: one access per 4 cycles, acks in cycles 3 and 7.
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b0; sel_v[0] = SEL_DRAM; addr_v[0] = 8'h20;
        @(posedge clk);
        am = 16'h0; dm = 16'h0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (ack_v[0]) am[c] = 1'b1;
            if (dram_en_v[0]) dm[c] = 1'b1;
            if (c == 7) req_v[0] = 1'b0;
        end
        chk("held_ack_cycles", am, 16'h0088);
        chk("held_en_cycles", dm, 16'h0022);
        chk("held_rdata", rdata_v[0], 8'h3C);
        last_rd[0] = 8'h3C;

        rand_run(0, 16);

        // Latency 3 instance.
        access(1, SEL_DRAM, 1'b1, 8'h20, 8'h3C, "l3_wr");
        access(1, SEL_DRAM, 1'b0, 8'h20, 8'h00, "l3_rd");
        access(1, SEL_IRAM, 1'b0, 8'h10, 8'h00, "l3_iram_rd");
        access(1, 2'b11, 1'b0, 8'h10, 8'h00, "l3_err");
        rand_run(1, 16);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
